// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between the two writeback requesters and the register file.
// Optional: RFARB_STALLCNT_EN adds the stall_count observation signal.
interface regfile_write_arbiter_if #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned ADDR_W = 5;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [NREGS-1:0]  wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
`ifdef RFARB_STALLCNT_EN
  logic [15:0]       stall_count;
`endif

  // Requester / observer side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr_en, wr_addr, wr_data
`ifdef RFARB_STALLCNT_EN
    , input stall_count
`endif
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr_en, wr_addr, wr_data
`ifdef RFARB_STALLCNT_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// pipeline writeback (req0) and the load/multi-cycle return path (req1).
// Optional: define RFARB_STALLCNT_EN to add a saturating stall counter.
module regfile_write_arbiter #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ZERO_REG = 31
) (
  input logic clk,
  input logic reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W = 5;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } prio_t;

  prio_t             state;
  prio_t             stateNext;
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic [NREGS-1:0]  wrEnNext;

  // Priority state register; reset favours req0 at the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LAST1;
    else        state <= stateNext;
  end

  // Grant selection and next priority state.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    stateNext = state;
    if (bus.req0_valid && bus.req1_valid) begin
      if (state == LAST0) grant1 = 1'b1;
      else                grant0 = 1'b1;
    end else if (bus.req0_valid) begin
      grant0 = 1'b1;
    end else if (bus.req1_valid) begin
      grant1 = 1'b1;
    end
    if (grant0)      stateNext = LAST0;
    else if (grant1) stateNext = LAST1;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Winning payload and its decoded enable; XZR and out-of-range drop the write.
  always_comb begin
    selAddr  = grant1 ? bus.req1_addr : bus.req0_addr;
    selData  = grant1 ? bus.req1_data : bus.req0_data;
    wrEnNext = '0;
    if ((32'(selAddr) != ZERO_REG) && (32'(selAddr) < NREGS))
      wrEnNext = NREGS'(1) << selAddr;
  end

  // Registered write port; enables pulse for one cycle per transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.wr_en   <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else if (grant0 || grant1) begin
      bus.wr_en   <= wrEnNext;
      bus.wr_addr <= selAddr;
      bus.wr_data <= selData;
    end else begin
      bus.wr_en   <= '0;
    end
  end

`ifdef RFARB_STALLCNT_EN
  logic [15:0] stallCnt;
  logic        stall;

  assign stall = (bus.req0_valid && !grant0) || (bus.req1_valid && !grant1);

  // Saturating count of edges where some requester was held off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          stallCnt <= '0;
    else if (stall && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
  end

  assign bus.stall_count = stallCnt;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vectors, literal spot checks and a
// per-cycle comparison against a transfer-level model of the write port.
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nChecks = 0;
  int   nErrors = 0;

  regfile_write_arbiter_if #(.NREGS(32), .DATA_W(64)) bus ();

  regfile_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: who won last, and what the write port must show after the next edge.
  int          mLast;
  logic [31:0] mWrEn;
  logic [4:0]  mWrAddr;
  logic [63:0] mWrData;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: readys against the arbitration rule, write port against
  // the transfer the model recorded at the preceding edge.
  always @(negedge clk) begin
    int winner;
    if (!reset) begin
      mLast   = 1;
      mWrEn   = '0;
      mWrAddr = '0;
      mWrData = '0;
    end
    winner = -1;
    if (bus.req0_valid && bus.req1_valid) winner = 1 - mLast;
    else if (bus.req0_valid)              winner = 0;
    else if (bus.req1_valid)              winner = 1;
    check("m_ready0", 64'(bus.req0_ready), 64'(winner == 0));
    check("m_ready1", 64'(bus.req1_ready), 64'(winner == 1));
    check("m_wr_en",   64'(bus.wr_en),   64'(mWrEn));
    check("m_wr_addr", 64'(bus.wr_addr), 64'(mWrAddr));
    check("m_wr_data", bus.wr_data, mWrData);
    if (reset) begin
      if (winner >= 0) begin
        mWrAddr = (winner == 0) ? bus.req0_addr : bus.req1_addr;
        mWrData = (winner == 0) ? bus.req0_data : bus.req1_data;
        mWrEn   = (mWrAddr == 5'd31) ? 32'h0 : (32'h1 << mWrAddr);
        mLast   = winner;
      end else begin
        mWrEn = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [63:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  localparam logic [63:0] DA = 64'hAAAA_0000_AAAA_0001;
  localparam logic [63:0] DB = 64'hBBBB_0000_BBBB_0002;

  initial begin
    setReq(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #2;
    check("rst_wr_en", 64'(bus.wr_en), 64'h0);
    check("rst_wr_data", bus.wr_data, 64'h0);
`ifdef RFARB_STALLCNT_EN
    check("rst_stall", 64'(bus.stall_count), 64'h0);
`endif
    step(); step();
    reset = 1'b1;

    // req0 alone to r5.
    step();
    setReq(1'b1, 5'd5, 64'h12345678_ABCDEF01, 1'b0, 5'd0, 64'd0);
    #1 check("a_ready0", 64'(bus.req0_ready), 64'h1);
    step();
    setReq(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #1 check("a_wr_en", 64'(bus.wr_en), 64'h20);
    check("a_wr_data", bus.wr_data, 64'h12345678_ABCDEF01);
    step();
    check("a_wr_en_off", 64'(bus.wr_en), 64'h0);

    // req1 to XZR: accepted, dropped, priority moves to LAST1.
    setReq(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hDEADBEEF_CAFEFADE);
    #1 check("z_ready1", 64'(bus.req1_ready), 64'h1);
    step();
    setReq(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #1 check("z_wr_en", 64'(bus.wr_en), 64'h0);
    check("z_wr_data", bus.wr_data, 64'hDEADBEEF_CAFEFADE);
    check("z_wr_addr", 64'(bus.wr_addr), 64'd31);

    // Four cycles of contention: grants 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      step();
      setReq(1'b1, 5'd1, DA, 1'b1, 5'd2, DB);
      #1 check("c_ready0", 64'(bus.req0_ready), 64'((k % 2) == 0));
      check("c_ready1", 64'(bus.req1_ready), 64'((k % 2) == 1));
      if (k > 0) check("c_wr_en", 64'(bus.wr_en), ((k % 2) == 1) ? 64'h2 : 64'h4);
    end
    step();
    setReq(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #1 check("c_wr_en_last", 64'(bus.wr_en), 64'h4);

    // Idle three cycles: port holds, enables low.
    for (int k = 0; k < 3; k++) begin
      step();
      check("i_wr_en", 64'(bus.wr_en), 64'h0);
      check("i_wr_addr", 64'(bus.wr_addr), 64'd2);
      check("i_wr_data", bus.wr_data, DB);
    end

    // Priority unchanged by idle: req0 wins the next contention.
    step();
    setReq(1'b1, 5'd1, DA, 1'b1, 5'd2, DB);
    #1 check("p_ready0", 64'(bus.req0_ready), 64'h1);
    step();
    #1 check("p_wr_en", 64'(bus.wr_en), 64'h2);
    // Mid-cycle async reset discards the presented write immediately.
    #1 reset = 1'b0;
    #1 check("r_wr_en", 64'(bus.wr_en), 64'h0);
    check("r_wr_data", bus.wr_data, 64'h0);
    step();
    reset = 1'b1;
    #1 check("r_first_ready0", 64'(bus.req0_ready), 64'h1);
    check("r_first_ready1", 64'(bus.req1_ready), 64'h0);

`ifdef RFARB_STALLCNT_EN
    // Ten contention edges from a cleared counter.
    repeat (10) step();
    setReq(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #1 check("s_count10", 64'(bus.stall_count), 64'd10);
    @(negedge clk);
    force dut.stallCnt = 16'hFFFD;
    #1 release dut.stallCnt;
    step();
    setReq(1'b1, 5'd3, DA, 1'b1, 5'd4, DB);
    repeat (3) step();
    setReq(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #1 check("s_saturate", 64'(bus.stall_count), 64'hFFFF);
`else
    step();
    setReq(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
`endif

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
